// File: rtl/drawbridge_pkg.sv
// Shared definitions for the drawbridge controller: state encoding and a popcount helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package drawbridge_pkg;

    // Encodings are visible on the State port, so the values are fixed.
    typedef enum logic [2:0] {
        ST_FLAT     = 3'd0,
        ST_CLEARING = 3'd1,
        ST_LIFTING  = 3'd2,
        ST_UPRIGHT  = 3'd3,
        ST_LOWERING = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    // Callers zero-extend their lane vectors to this width.
    localparam int POP_W = 32;

    function automatic int unsigned popcount(input logic [POP_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_W; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/car_counter.sv
// Saturating count of vehicles on the deck from per-lane entry/exit pulses.
// Latency: pulses appear in count one cycle later.
// Backpressure: none; every pulse is accepted, excess clamps at 0 / full scale.
// Ports: Clk, Reset (async active-low), car_in/car_out (one pulse per vehicle per lane),
//        count (vehicles currently on the deck).
module car_counter
    import drawbridge_pkg::*;
#(
    parameter int LANES = 2,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [LANES-1:0] car_in,
    input  logic [LANES-1:0] car_out,
    output logic [CNT_W-1:0] count
);

    // Two guard bits: one for the sign, one so count + LANES cannot overflow.
    localparam int SW = CNT_W + 2;

    logic [CNT_W-1:0]     count_q, count_d;
    logic signed [SW-1:0] net;

    always_comb begin
        net = $signed({2'b00, count_q})
            + $signed(SW'(popcount(POP_W'(car_in))))
            - $signed(SW'(popcount(POP_W'(car_out))));
        if (net[SW-1]) begin
            count_d = '0;                      // more exits than vehicles: floor at 0
        end else if (net[SW-2:CNT_W] != '0) begin
            count_d = '1;                      // above full scale: hold at max
        end else begin
            count_d = net[CNT_W-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/drawbridge_ctrl.sv
// Drawbridge sequencer: clears the deck, raises, holds, lowers; latches FAULT on timeout/sensor errors.
// Latency: state changes one Clk after its condition is sampled; outputs decode State combinationally.
// Backpressure: none; sensors and buttons are sampled every cycle.
// Ports: Clk, Reset (async active-low); CarIn/CarOut per-lane vehicle pulses; Mode (0 auto, 1 manual);
//        PowerBtn, BoatSensor requests; High/Low limit switches; Motor, MotorDir (1 raise), Alarm,
//        TrafficLight (1 road closed); State encoding; CarCount vehicles on deck.
module drawbridge_ctrl
    import drawbridge_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int CNT_W      = 6,
    parameter int TRAVEL_MAX = 1000,
    parameter int HOLD_CYC   = 200
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [LANES-1:0] CarIn,
    input  logic [LANES-1:0] CarOut,
    input  logic             Mode,
    input  logic             PowerBtn,
    input  logic             BoatSensor,
    input  logic             High,
    input  logic             Low,
    output logic             Motor,
    output logic             MotorDir,
    output logic             Alarm,
    output logic             TrafficLight,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] CarCount
);

    localparam int TMR_W  = $clog2(TRAVEL_MAX + 1);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              pwr_q, pwr_d;

    logic req, sensor_err, pwr_rise, deck_busy;

    car_counter #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) u_car_counter (
        .Clk     (Clk),
        .Reset   (Reset),
        .car_in  (CarIn),
        .car_out (CarOut),
        .count   (CarCount)
    );

    assign req        = Mode ? PowerBtn : BoatSensor;
    assign sensor_err = High & Low;
    assign pwr_rise   = PowerBtn & ~pwr_q;
    assign deck_busy  = (CarCount != '0);
    assign pwr_d      = PowerBtn;
    assign State      = state_q;

    // Moore decode; a vehicle on the deck pauses the motor and sounds the alarm.
    always_comb begin
        Motor        = 1'b0;
        MotorDir     = 1'b0;
        Alarm        = 1'b0;
        TrafficLight = 1'b0;
        case (state_q)
            ST_CLEARING: begin
                TrafficLight = 1'b1;
                Alarm        = deck_busy;
            end
            ST_LIFTING: begin
                TrafficLight = 1'b1;
                MotorDir     = 1'b1;
                Motor        = ~deck_busy;
                Alarm        = deck_busy;
            end
            ST_UPRIGHT: begin
                TrafficLight = 1'b1;
            end
            ST_LOWERING: begin
                TrafficLight = 1'b1;
                Motor        = ~deck_busy;
                Alarm        = deck_busy;
            end
            ST_FAULT: begin
                TrafficLight = 1'b1;
                Alarm        = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (state_q != ST_FAULT && sensor_err) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_FLAT: begin
                    if (!Low || High)  state_d = ST_FAULT;
                    else if (req)      state_d = ST_CLEARING;
                end
                ST_CLEARING: begin
                    if (!req)            state_d = ST_FLAT;
                    else if (!deck_busy) state_d = ST_LIFTING;
                end
                ST_LIFTING: begin
                    if (High)                                    state_d = ST_UPRIGHT;
                    else if (timer_q == TMR_W'(TRAVEL_MAX - 1))  state_d = ST_FAULT;
                end
                ST_UPRIGHT: begin
                    if (!High)                                        state_d = ST_FAULT;
                    else if (!req && hold_q >= HOLD_W'(HOLD_CYC))     state_d = ST_LOWERING;
                end
                ST_LOWERING: begin
                    // A late boat re-raises regardless of Mode.
                    if (BoatSensor)                              state_d = ST_LIFTING;
                    else if (Low)                                state_d = ST_FLAT;
                    else if (timer_q == TMR_W'(TRAVEL_MAX - 1))  state_d = ST_FAULT;
                end
                ST_FAULT: begin
                    if (pwr_rise && Low && !High) state_d = ST_FLAT;
                end
                default: state_d = ST_FAULT;
            endcase
        end
    end

    // Travel timer restarts on every entry to a travel state and only counts while the motor runs.
    always_comb begin
        timer_d = timer_q;
        if ((state_d == ST_LIFTING || state_d == ST_LOWERING) && state_d != state_q) begin
            timer_d = '0;
        end else if (Motor) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_comb begin
        hold_d = hold_q;
        if (state_d == ST_UPRIGHT && state_q != ST_UPRIGHT) begin
            hold_d = '0;
        end else if (state_q == ST_UPRIGHT && hold_q < HOLD_W'(HOLD_CYC)) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_FLAT;
            timer_q <= '0;
            hold_q  <= '0;
            pwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            hold_q  <= hold_d;
            pwr_q   <= pwr_d;
        end
    end

endmodule

// File: tb/tb_drawbridge_ctrl.sv
// Bench for drawbridge_ctrl: directed scenarios plus randomized traffic and deck motion,
// every cycle compared against a behavioural model of the controller rules.
// Ports: none (top-level bench).
module tb_drawbridge_ctrl;

    localparam int LANES = 2;
    localparam int CNT_W = 2;
    localparam int TM    = 100;
    localparam int HC    = 20;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int OUT_W = 7 + CNT_W;

    // State numbers as published on the State port.
    localparam int S_FLAT = 0, S_CLR = 1, S_LIFT = 2, S_UP = 3, S_LOW = 4, S_FAULT = 5;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic [LANES-1:0] CarIn = '0;
    logic [LANES-1:0] CarOut = '0;
    logic             Mode = 1'b0;
    logic             PowerBtn = 1'b0;
    logic             BoatSensor = 1'b0;
    logic             High = 1'b0;
    logic             Low = 1'b0;
    logic             Motor, MotorDir, Alarm, TrafficLight;
    logic [2:0]       State;
    logic [CNT_W-1:0] CarCount;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    drawbridge_ctrl #(
        .LANES      (LANES),
        .CNT_W      (CNT_W),
        .TRAVEL_MAX (TM),
        .HOLD_CYC   (HC)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .CarIn        (CarIn),
        .CarOut       (CarOut),
        .Mode         (Mode),
        .PowerBtn     (PowerBtn),
        .BoatSensor   (BoatSensor),
        .High         (High),
        .Low          (Low),
        .Motor        (Motor),
        .MotorDir     (MotorDir),
        .Alarm        (Alarm),
        .TrafficLight (TrafficLight),
        .State        (State),
        .CarCount     (CarCount)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int st;
        int cnt;
        int timer;
        int hold;
        bit prev;
    } mstate_t;

    mstate_t m = '{st: 0, cnt: 0, timer: 0, hold: 0, prev: 1'b0};

    function automatic logic [OUT_W-1:0] model_out(int st, int cnt);
        logic motor, dir, alarm, road;
        motor = 0; dir = 0; alarm = 0; road = 0;
        case (st)
            S_CLR:   begin road = 1; alarm = (cnt != 0); end
            S_LIFT:  begin road = 1; dir = 1; motor = (cnt == 0); alarm = (cnt != 0); end
            S_UP:    begin road = 1; end
            S_LOW:   begin road = 1; motor = (cnt == 0); alarm = (cnt != 0); end
            S_FAULT: begin road = 1; alarm = 1; end
            default: ;
        endcase
        return {3'(st), motor, dir, alarm, road, CNT_W'(cnt)};
    endfunction

    function automatic mstate_t step(mstate_t c, logic [LANES-1:0] ci, logic [LANES-1:0] co,
                                     logic mode, logic btn, logic boat, logic hi, logic lo);
        mstate_t n;
        bit req, rise, moving;
        int sum;
        n      = c;
        req    = mode ? btn : boat;
        rise   = btn && !c.prev;
        moving = (c.st == S_LIFT || c.st == S_LOW) && c.cnt == 0;
        if (c.st != S_FAULT && hi && lo) n.st = S_FAULT;
        else case (c.st)
            S_FLAT:  if (!lo || hi) n.st = S_FAULT; else if (req) n.st = S_CLR;
            S_CLR:   if (!req) n.st = S_FLAT; else if (c.cnt == 0) n.st = S_LIFT;
            S_LIFT:  if (hi) n.st = S_UP; else if (c.timer == TM - 1) n.st = S_FAULT;
            S_UP:    if (!hi) n.st = S_FAULT; else if (!req && c.hold >= HC) n.st = S_LOW;
            S_LOW:   if (boat) n.st = S_LIFT; else if (lo) n.st = S_FLAT;
                     else if (c.timer == TM - 1) n.st = S_FAULT;
            default: if (rise && lo && !hi) n.st = S_FLAT;
        endcase
        if ((n.st == S_LIFT || n.st == S_LOW) && n.st != c.st) n.timer = 0;
        else if (moving) n.timer = c.timer + 1;
        if (n.st == S_UP && c.st != S_UP) n.hold = 0;
        else if (c.st == S_UP && c.hold < HC) n.hold = c.hold + 1;
        sum = c.cnt + $countones(ci) - $countones(co);
        n.cnt  = (sum < 0) ? 0 : (sum > CMAX) ? CMAX : sum;
        n.prev = btn;
        return n;
    endfunction

    initial forever begin
        @(posedge Clk or negedge Reset);
        if (!Reset) m = '{st: 0, cnt: 0, timer: 0, hold: 0, prev: 1'b0};
        else        m = step(m, CarIn, CarOut, Mode, PowerBtn, BoatSensor, High, Low);
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [OUT_W-1:0] exp_v, act_v;
        @(negedge Clk);
        exp_v = model_out(m.st, m.cnt);
        act_v = {State, Motor, MotorDir, Alarm, TrafficLight, CarCount};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL outputs t=%0t {State,Motor,Dir,Alarm,Light,Count} actual=%b required=%b",
                     $time, act_v, exp_v);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Pins both the DUT and the model to a hand-derived state.
    task automatic expect_state(input string name, input int s);
        chk({name, "_dut"}, int'(State), s);
        chk({name, "_model"}, m.st, s);
    endtask

    int pos;

    initial begin
        // Reset
        tick(2);
        expect_state("reset", S_FLAT);
        chk("reset_count", int'(CarCount), 0);
        chk("reset_outs", int'({Motor, MotorDir, Alarm, TrafficLight}), 0);
        Reset = 1'b1;
        Low   = 1'b1;
        tick(2);
        expect_state("idle", S_FLAT);

        // Automatic cycle
        BoatSensor = 1'b1;
        tick(1); expect_state("auto_clear", S_CLR);
        tick(1); expect_state("auto_lift", S_LIFT);
        chk("auto_lift_motor", int'({Motor, MotorDir}), 3);
        Low = 1'b0;
        tick(10);
        High = 1'b1;
        tick(1); expect_state("auto_up", S_UP);
        BoatSensor = 1'b0;
        tick(HC); expect_state("auto_hold", S_UP);
        tick(1); expect_state("auto_lower", S_LOW);
        chk("auto_lower_motor", int'({Motor, MotorDir}), 2);
        High = 1'b0;
        tick(5);
        Low = 1'b1;
        tick(1); expect_state("auto_flat", S_FLAT);
        chk("auto_flat_outs", int'({Motor, MotorDir, Alarm, TrafficLight}), 0);

        // Deck clearing
        CarIn = 2'b11;
        tick(1); CarIn = 2'b00;
        chk("clear_count2", int'(CarCount), 2);
        BoatSensor = 1'b1;
        tick(1); expect_state("clear_enter", S_CLR);
        tick(1); expect_state("clear_hold", S_CLR);
        chk("clear_alarm", int'(Alarm), 1);
        CarOut = 2'b11;
        tick(1); CarOut = 2'b00;
        chk("clear_count0", int'(CarCount), 0);
        expect_state("clear_still", S_CLR);
        tick(1); expect_state("clear_lift", S_LIFT);

        // Travel timeout (High stays 0)
        tick(TM - 1); expect_state("tmo_before", S_LIFT);
        tick(1); expect_state("tmo_fault", S_FAULT);
        chk("tmo_outs", int'({Motor, Alarm}), 1);
        BoatSensor = 1'b0;
        PowerBtn   = 1'b1;
        tick(1); expect_state("tmo_recover", S_FLAT);
        PowerBtn = 1'b0;

        // Re-raise from LOWERING at timer 50
        BoatSensor = 1'b1;
        tick(2); expect_state("rr_lift", S_LIFT);
        Low = 1'b0; High = 1'b1;
        tick(1); expect_state("rr_up", S_UP);
        BoatSensor = 1'b0;
        tick(HC + 1); expect_state("rr_lower", S_LOW);
        High = 1'b0;
        tick(50);
        BoatSensor = 1'b1;
        tick(1); expect_state("rr_relift", S_LIFT);
        chk("rr_dir", int'(MotorDir), 1);
        tick(TM - 1); expect_state("rr_timer_cleared", S_LIFT);
        tick(1); expect_state("rr_fault", S_FAULT);
        BoatSensor = 1'b0; Low = 1'b1; PowerBtn = 1'b1;
        tick(1); expect_state("rr_recover", S_FLAT);
        PowerBtn = 1'b0;

        // Sensor error in UPRIGHT
        BoatSensor = 1'b1;
        tick(2); expect_state("se_lift", S_LIFT);
        Low = 1'b0; High = 1'b1;
        tick(1); expect_state("se_up", S_UP);
        Low = 1'b1;
        tick(1); expect_state("se_fault", S_FAULT);
        PowerBtn = 1'b1;
        tick(1); expect_state("se_btn_high", S_FAULT);
        PowerBtn = 1'b0; High = 1'b0; BoatSensor = 1'b0;
        tick(1);
        PowerBtn = 1'b1;
        tick(1); expect_state("se_recover", S_FLAT);
        PowerBtn = 1'b0;

        // Manual mode request
        Mode = 1'b1;
        tick(1); expect_state("man_idle", S_FLAT);
        PowerBtn = 1'b1;
        tick(1); expect_state("man_clear", S_CLR);
        PowerBtn = 1'b0;
        tick(1); expect_state("man_drop", S_FLAT);
        Mode = 1'b0;

        // Counter saturation and same-lane netting
        CarIn = 2'b01;
        tick(5); CarIn = 2'b00;
        chk("sat_high", int'(CarCount), 3);
        CarOut = 2'b01;
        tick(4); CarOut = 2'b00;
        chk("sat_low", int'(CarCount), 0);
        CarIn = 2'b01;
        tick(1);
        CarIn = 2'b10; CarOut = 2'b10;
        tick(1); CarIn = 2'b00; CarOut = 2'b00;
        chk("net_zero", int'(CarCount), 1);
        CarOut = 2'b11;
        tick(1); CarOut = 2'b00;
        chk("floor_zero", int'(CarCount), 0);

        // Reset during travel, deck not lowered
        BoatSensor = 1'b1;
        tick(2); expect_state("rst_lift", S_LIFT);
        Low = 1'b0;
        tick(3);
        #1 Reset = 1'b0;
        tick(1); expect_state("rst_flat", S_FLAT);
        chk("rst_motor", int'(Motor), 0);
        #1 Reset = 1'b1;
        BoatSensor = 1'b0;
        tick(1); expect_state("rst_fault", S_FAULT);
        Low = 1'b1; PowerBtn = 1'b1;
        tick(1); expect_state("rst_recover", S_FLAT);
        PowerBtn = 1'b0;

        // Randomized traffic with a simple deck position that follows the motor
        pos = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge Clk);
            if (Motor) pos = MotorDir ? pos + 1 : pos - 1;
            if (pos < 0) pos = 0;
            if (pos > 30) pos = 30;
            High = (pos == 30);
            Low  = (pos == 0);
            if ($urandom_range(0, 199) == 0) begin High = 1'b1; Low = 1'b1; end
            if ($urandom_range(0, 199) == 0) Low = ~Low;
            CarIn  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            CarOut = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            if ($urandom_range(0, 29) == 0)  BoatSensor = ~BoatSensor;
            if ($urandom_range(0, 19) == 0)  PowerBtn = ~PowerBtn;
            if ($urandom_range(0, 299) == 0) Mode = ~Mode;
            if ($urandom_range(0, 499) == 0) begin
                #1 Reset = 1'b0;
                @(negedge Clk);
                #1 Reset = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
